mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_if.sv | 32 +++
 rtl/mc_ctrl.sv | 62 ++++++
 tb/tb_mc_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: decode inputs, memory handshakes and datapath strobes of the mc_ctrl controller
interface mc_ctrl_if;
  logic [5:0] instr_op;
  logic [5:0] instr_funct;
  logic       alu_zero;
  logic       imem_req;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_we;
  logic       dmem_ready;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       ir_we;
  logic [7:0] ext_op;
  logic [2:0] alu_op;
  logic       alu_src_imm;
  logic       rf_we;
  logic [1:0] rf_wa_sel;
  logic [1:0] rf_wd_sel;
  logic       instr_done;
  logic       trap;
  modport master (
    input  instr_op, instr_funct, alu_zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, pc_we, pc_sel, ir_we, ext_op, alu_op,
           alu_src_imm, rf_we, rf_wa_sel, rf_wd_sel, instr_done, trap
  );
  modport slave (
    output instr_op, instr_funct, alu_zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, pc_we, pc_sel, ir_we, ext_op, alu_op,
           alu_src_imm, rf_we, rf_wa_sel, rf_wd_sel, instr_done, trap
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM; define MC_CTRL_PERF_EN to add the retired_cnt counter
module mc_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  mc_ctrl_if.master   bus
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] retired_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t r_state;
  logic w_rtype, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_jal;
  logic w_legal, w_act, w_fetched, w_link, w_done;
  assign w_subu    = bus.instr_op == 6'h00 && bus.instr_funct == 6'h23;
  assign w_rtype   = bus.instr_op == 6'h00 && (bus.instr_funct == 6'h21 || bus.instr_funct == 6'h00 || w_subu);
  assign w_jr      = bus.instr_op == 6'h00 && bus.instr_funct == 6'h08;
  assign w_ori     = bus.instr_op == 6'h0D;
  assign w_lui     = bus.instr_op == 6'h0F;
  assign w_lw      = bus.instr_op == 6'h23;
  assign w_sw      = bus.instr_op == 6'h2B;
  assign w_beq     = bus.instr_op == 6'h04;
  assign w_jal     = bus.instr_op == 6'h03;
  assign w_legal   = w_rtype | w_jr | w_ori | w_lui | w_lw | w_sw | w_beq | w_jal;
  assign w_act     = r_state inside {DECODE, EXEC, MEM, WB};
  assign w_fetched = r_state == FETCH && bus.imem_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else case (r_state)
      IDLE:    r_state <= FETCH;
      FETCH:   r_state <= bus.imem_ready ? DECODE : FETCH;
      DECODE:  r_state <= w_legal ? EXEC : TRAP;
      EXEC:    r_state <= (w_beq | w_jal | w_jr) ? FETCH : (w_lw | w_sw) ? MEM : WB;
      MEM:     r_state <= !bus.dmem_ready ? MEM : w_sw ? FETCH : WB;
      WB:      r_state <= FETCH;
      default: r_state <= TRAP;
    endcase
  // Strobes qualify the state with handshake/flag inputs so they land in the accepting cycle.
  assign w_link          = r_state == EXEC && w_jal;
  assign w_done          = (r_state == EXEC && (w_beq | w_jal | w_jr)) || (r_state == MEM && w_sw && bus.dmem_ready) || r_state == WB;
  assign bus.imem_req    = r_state == FETCH;
  assign bus.ir_we       = w_fetched;
  assign bus.pc_we       = w_fetched | (r_state == EXEC && (w_beq ? bus.alu_zero : w_jal | w_jr));
  assign bus.pc_sel      = r_state != EXEC ? 2'd0 : w_beq ? 2'd1 : w_jal ? 2'd2 : w_jr ? 2'd3 : 2'd0;
  assign bus.ext_op      = !w_act ? 8'd0 : w_lui ? 8'd2 : (w_lw | w_sw | w_beq) ? 8'd1 : 8'd0;
  assign bus.alu_op      = !w_act ? 3'd0 : (w_subu | w_beq) ? 3'd1 : w_ori ? 3'd2 : 3'd0;
  assign bus.alu_src_imm = w_act & (w_ori | w_lui | w_lw | w_sw);
  assign bus.dmem_req    = r_state == MEM;
  assign bus.dmem_we     = r_state == MEM && w_sw;
  assign bus.rf_we       = r_state == WB || w_link;
  assign bus.rf_wa_sel   = w_link ? 2'd2 : (r_state == WB && w_rtype) ? 2'd1 : 2'd0;
  assign bus.rf_wd_sel   = w_link ? 2'd2 : (r_state == WB && w_lw) ? 2'd1 : 2'd0;
  assign bus.instr_done  = w_done;
  assign bus.trap        = r_state == TRAP;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_retired_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_retired_cnt <= '0;
    else if (w_done) r_retired_cnt <= r_retired_cnt + 32'd1;
  assign retired_cnt = r_retired_cnt;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: per-cycle trace model of mc_ctrl driven by a program table with memory wait states
module tb_mc_ctrl;
  typedef struct packed {
    logic imem_req, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic dmem_req, dmem_we;
    logic [7:0] ext_op;
    logic [2:0] alu_op;
    logic alu_src_imm, rf_we;
    logic [1:0] rf_wa_sel, rf_wd_sel;
    logic instr_done, trap;
  } out_t;
  typedef struct packed {
    logic [5:0] op, fn;
    logic z;
    logic [7:0] iw, dw;
  } prog_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  mc_ctrl_if bus();
`ifdef MC_CTRL_PERF_EN
  logic [31:0] retired_cnt;
  mc_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus), .retired_cnt(retired_cnt));
`else
  mc_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  out_t got;
  assign got = {bus.imem_req, bus.ir_we, bus.pc_we, bus.pc_sel, bus.dmem_req, bus.dmem_we, bus.ext_op,
                bus.alu_op, bus.alu_src_imm, bus.rf_we, bus.rf_wa_sel, bus.rf_wd_sel, bus.instr_done, bus.trap};
  prog_t prog [16];
  int    nprog = 0;
  int    fidx = 0;
  prog_t cur;
  logic  take;
  int    icnt = 0, dcnt = 0;
  out_t  exp_q[$], msk_q[$];
  int    done_q[$];
  int    cyc = 0, n_chk = 0, n_fail = 0;
  // Instruction memory, IR register and data memory responders
  initial begin
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.alu_zero = 1'b0;
    bus.instr_op = 6'h00; bus.instr_funct = 6'h00; cur = '0;
    forever begin
      @(negedge clk);
      take = bus.ir_we;
      @(posedge clk);
      #1;
      if (!reset_n) begin fidx = 0; take = 1'b0; end
      if (take && fidx < nprog) begin
        cur = prog[fidx];
        bus.instr_op = cur.op; bus.instr_funct = cur.fn; bus.alu_zero = cur.z;
        fidx++;
      end
      if (bus.imem_req && fidx < nprog) begin bus.imem_ready = icnt == int'(prog[fidx].iw); icnt++; end
      else begin bus.imem_ready = 1'b0; icnt = 0; end
      if (bus.dmem_req) begin bus.dmem_ready = dcnt == int'(cur.dw); dcnt++; end
      else begin bus.dmem_ready = 1'b0; dcnt = 0; end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic push(input out_t e, input out_t m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask
  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic [7:0] iw, input logic [7:0] dw);
    prog[nprog] = '{op, fn, z, iw, dw};
    nprog++;
  endtask
  task automatic push_instr(input prog_t p);
    out_t r, d, m;
    logic rt, sub, jr, ori, lui, lw, sw, beq, jal;
    rt  = p.op == 6'h00 && (p.fn == 6'h21 || p.fn == 6'h23 || p.fn == 6'h00);
    sub = p.op == 6'h00 && p.fn == 6'h23;
    jr  = p.op == 6'h00 && p.fn == 6'h08;
    ori = p.op == 6'h0D; lui = p.op == 6'h0F; lw = p.op == 6'h23;
    sw  = p.op == 6'h2B; beq = p.op == 6'h04; jal = p.op == 6'h03;
    r = '0; r.imem_req = 1'b1;
    repeat (p.iw) push(r, '1);
    r.ir_we = 1'b1; r.pc_we = 1'b1;
    push(r, '1);
    d = '0;
    d.ext_op = lui ? 8'd2 : (lw || sw || beq) ? 8'd1 : 8'd0;
    d.alu_op = (sub || beq) ? 3'd1 : ori ? 3'd2 : 3'd0;
    d.alu_src_imm = ori || lui || lw || sw;
    m = '1; m.alu_op = '0;
    push(d, m);
    if (!(rt || jr || ori || lui || lw || sw || beq || jal)) return;
    r = d;
    if (beq || jal || jr) begin
      r.pc_we = beq ? p.z : 1'b1;
      r.pc_sel = beq ? 2'd1 : jal ? 2'd2 : 2'd3;
      r.rf_we = jal;
      r.rf_wa_sel = jal ? 2'd2 : 2'd0;
      r.rf_wd_sel = jal ? 2'd2 : 2'd0;
      r.instr_done = 1'b1;
      push(r, '1);
      return;
    end
    push(d, '1);
    if (lw || sw) begin
      r.dmem_req = 1'b1; r.dmem_we = sw;
      repeat (p.dw) push(r, '1);
      r.instr_done = sw;
      push(r, '1);
      if (sw) return;
    end
    r = d; r.rf_we = 1'b1;
    r.rf_wa_sel = rt ? 2'd1 : 2'd0;
    r.rf_wd_sel = lw ? 2'd1 : 2'd0;
    r.instr_done = 1'b1;
    push(r, '1);
  endtask
  task automatic push_idle();
    push('0, '1);
  endtask
  task automatic push_stall();
    out_t r;
    r = '0; r.imem_req = 1'b1;
    push(r, '1);
  endtask
  task automatic cycle();
    out_t e, m;
    @(negedge clk);
    cyc = reset_n ? cyc + 1 : 0;
    if (!reset_n) done_q.delete();
    else if (bus.instr_done) done_q.push_back(cyc);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      chk($sformatf("cyc%0d_outputs", cyc), 32'(got & m), 32'(e & m));
    end
  endtask
  task automatic run_until_empty(input int limit);
    int n = 0;
    while (exp_q.size() > 0 && n < limit) begin cycle(); n++; end
    chk("trace_drained", exp_q.size(), 0);
    exp_q.delete();
    msk_q.delete();
  endtask
  task automatic start_reset();
    reset_n = 1'b0;
    #1;
    chk("reset_outputs_zero", 32'(got), 0);
    repeat (2) cycle();
  endtask
  task automatic release_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask
  function automatic int qget(input int i);
    return i < done_q.size() ? done_q[i] : -1;
  endfunction
  initial begin
    #3;
    start_reset();
    nprog = 0;
    add(6'h0D, 6'h00, 1'b0, 8'd0, 8'd0);
    add(6'h23, 6'h00, 1'b0, 8'd0, 8'd3);
    add(6'h04, 6'h00, 1'b0, 8'd0, 8'd0);
    add(6'h04, 6'h00, 1'b1, 8'd0, 8'd0);
    add(6'h03, 6'h00, 1'b0, 8'd1, 8'd0);
    add(6'h00, 6'h08, 1'b0, 8'd0, 8'd0);
    add(6'h00, 6'h21, 1'b0, 8'd2, 8'd0);
    add(6'h00, 6'h23, 1'b0, 8'd0, 8'd0);
    add(6'h00, 6'h00, 1'b0, 8'd0, 8'd0);
    add(6'h2B, 6'h00, 1'b0, 8'd1, 8'd2);
    add(6'h0F, 6'h00, 1'b0, 8'd0, 8'd0);
    add(6'h2B, 6'h00, 1'b0, 8'd0, 8'd0);
    push_idle();
    for (int i = 0; i < nprog; i++) push_instr(prog[i]);
    push_stall();
    release_reset();
    run_until_empty(400);
    chk("seg1_retire_count", done_q.size(), 12);
    chk("ori_retire_cycle", qget(0), 5);
    chk("lw_wait3_retire_cycle", qget(1), 13);
    chk("beq_z0_retire_cycle", qget(2), 16);
    chk("beq_z1_retire_cycle", qget(3), 19);
`ifdef MC_CTRL_PERF_EN
    chk("seg1_retired_cnt", retired_cnt, 12);
`endif
    start_reset();
`ifdef MC_CTRL_PERF_EN
    chk("retired_cnt_after_reset", retired_cnt, 0);
`endif
    nprog = 0;
    add(6'h3F, 6'h00, 1'b0, 8'd0, 8'd0);
    push_idle();
    push_instr(prog[0]);
    begin
      out_t t;
      t = '0; t.trap = 1'b1;
      repeat (20) push(t, '1);
    end
    release_reset();
    run_until_empty(100);
    chk("trap_held", 32'(bus.trap), 1);
    chk("trap_no_retire", done_q.size(), 0);
    start_reset();
    nprog = 0;
    push_idle();
    push_stall();
    release_reset();
    run_until_empty(10);
    start_reset();
    nprog = 0;
    add(6'h2B, 6'h00, 1'b0, 8'd0, 8'd10);
    push_idle();
    push_instr(prog[0]);
    while (exp_q.size() > 7) begin void'(exp_q.pop_back()); void'(msk_q.pop_back()); end
    release_reset();
    run_until_empty(20);
    chk("sw_waiting_dmem_req", 32'(bus.dmem_req), 1);
    chk("sw_waiting_no_retire", done_q.size(), 0);
    reset_n = 1'b0;
    #1;
    chk("abort_dmem_req", 32'(bus.dmem_req), 0);
    chk("abort_dmem_we", 32'(bus.dmem_we), 0);
    chk("abort_instr_done", 32'(bus.instr_done), 0);
`ifdef MC_CTRL_PERF_EN
    chk("abort_retired_cnt", retired_cnt, 0);
`endif
    repeat (2) cycle();
    nprog = 0;
    for (int i = 0; i < 10; i++) add(6'h0F, 6'h00, 1'b0, 8'd0, 8'd0);
    push_idle();
    for (int i = 0; i < nprog; i++) push_instr(prog[i]);
    push_stall();
    release_reset();
    run_until_empty(200);
    chk("lui10_retire_count", done_q.size(), 10);
    chk("lui10_last_retire_cycle", qget(9), 41);
`ifdef MC_CTRL_PERF_EN
    chk("lui10_retired_cnt", retired_cnt, 10);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
